// File: rtl/inst_encoder.sv
// inst_encoder: packs decoded instruction fields into 32-bit Controller words,
// buffers them in a 4-entry FIFO and writes them to instruction memory at an
// auto-incrementing address.
// Optional build macro INST_ENC_IMM_CHECK_EN: tuples whose immediate does not
// fit in 9 bits are handshaken but dropped, and err pulses.
module inst_encoder #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_rd,
    input  logic [5:0]        in_rs,
    input  logic [5:0]        in_rt,
    input  logic [3:0]        in_aluop,
    input  logic              in_muxsel,
    input  logic [15:0]       in_imm,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] addr_base,
    input  logic              mem_busy,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [15:0]       wr_count,
    output logic              wrapped,
    output logic              err
);

    localparam int unsigned DEPTH = 4;

    logic [31:0]       fifo_q [DEPTH];
    logic [1:0]        wr_ptr_q, rd_ptr_q;
    logic [2:0]        count_q;
    logic [ADDR_W-1:0] addr_cnt_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic [15:0]       wr_count_q;
    logic              wrapped_q;
    logic              err_q;

    logic        full, empty;
    logic        accept, imm_bad, push, pop;
    logic        load_ok, load_err;
    logic [31:0] enc_word;

    // Handshake, FIFO control and address-load qualification
    always_comb begin
        full     = (count_q == 3'(DEPTH));
        empty    = (count_q == 3'd0);
        // Ready comes from the registered count only, so a same-cycle pop
        // never lets a new tuple through a full FIFO.
        in_ready = rst_n & ~full;
        accept   = in_valid & in_ready;
`ifdef INST_ENC_IMM_CHECK_EN
        imm_bad  = |in_imm[15:9];
`else
        imm_bad  = 1'b0;
`endif
        push     = accept & ~imm_bad;
        pop      = ~empty & ~mem_busy;
        // A load is safe only when nothing is queued or in flight.
        load_ok  = addr_load & empty & ~mem_we_q;
        load_err = addr_load & ~load_ok;
        enc_word = {in_muxsel, in_rd, in_rs, in_aluop, in_rt, in_imm[8:0]};
    end

`ifndef INST_ENC_IMM_CHECK_EN
    logic unused_imm_hi;
    assign unused_imm_hi = ^in_imm[15:9];
`endif

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) fifo_q[i] <= 32'd0;
        end else if (push) begin
            fifo_q[wr_ptr_q] <= enc_word;
        end
    end

    // Memory write port: registered strobe, address and data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            wr_count_q  <= 16'd0;
        end else begin
            mem_we_q <= pop;
            if (pop) begin
                mem_addr_q  <= addr_cnt_q;
                mem_wdata_q <= fifo_q[rd_ptr_q];
                if (wr_count_q != 16'hFFFF) wr_count_q <= wr_count_q + 16'd1;
            end
        end
    end

    // Address counter with base load and sticky wrap flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_cnt_q <= '0;
            wrapped_q  <= 1'b0;
        end else if (load_ok) begin
            addr_cnt_q <= addr_base;
            wrapped_q  <= 1'b0;
        end else if (pop) begin
            addr_cnt_q <= addr_cnt_q + ADDR_W'(1);
            if (&addr_cnt_q) wrapped_q <= 1'b1;
        end
    end

    // One-cycle error pulse for a rejected load or a dropped tuple
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= load_err | (accept & imm_bad);
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign wr_count  = wr_count_q;
    assign wrapped   = wrapped_q;
    assign err       = err_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: directed scenarios plus a random phase, all writes
// checked by a scoreboard monitor against a field-level reference model.
module tb_inst_encoder;

    localparam int ADDR_W = 8;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [5:0]        in_rd, in_rs, in_rt;
    logic [3:0]        in_aluop;
    logic              in_muxsel;
    logic [15:0]       in_imm;
    logic              addr_load;
    logic [ADDR_W-1:0] addr_base;
    logic              mem_busy;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [15:0]       wr_count;
    logic              wrapped;
    logic              err;

    inst_encoder #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rd     (in_rd),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_aluop  (in_aluop),
        .in_muxsel (in_muxsel),
        .in_imm    (in_imm),
        .addr_load (addr_load),
        .addr_base (addr_base),
        .mem_busy  (mem_busy),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .wr_count  (wr_count),
        .wrapped   (wrapped),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0]       exp_q[$];
    logic [ADDR_W-1:0] model_addr = '0;
    int                exp_wr = 0;
    bit                exp_wrapped = 1'b0;
    int                exp_err = 0;
    int                err_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Field placement as plain arithmetic
    function automatic logic [31:0] model_word(input int rd, input int rs, input int rt,
                                               input int op, input int mux, input int imm);
        longint unsigned w;
        w = longint'(mux) * 64'd2147483648 + longint'(rd) * 64'd33554432
          + longint'(rs) * 64'd524288 + longint'(op) * 64'd32768
          + longint'(rt) * 64'd512 + longint'(imm % 512);
        return w[31:0];
    endfunction

    function automatic bit imm_dropped(input logic [15:0] imm);
`ifdef INST_ENC_IMM_CHECK_EN
        return imm > 16'd511;
`else
        return 1'b0;
`endif
    endfunction

    // Called just after driving inputs at a negedge: predicts the coming edge.
    function automatic bit note_accept();
        if (in_valid && in_ready) begin
            if (imm_dropped(in_imm)) exp_err++;
            else exp_q.push_back(model_word(in_rd, in_rs, in_rt, in_aluop, in_muxsel, in_imm));
            return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic void clear_model();
        exp_q.delete();
        model_addr  = '0;
        exp_wr      = 0;
        exp_wrapped = 1'b0;
    endfunction

    task automatic set_rand(input bit small_imm);
        in_rd     = 6'($urandom);
        in_rs     = 6'($urandom);
        in_rt     = 6'($urandom);
        in_aluop  = 4'($urandom);
        in_muxsel = 1'($urandom);
        in_imm    = small_imm ? 16'($urandom_range(0, 511)) : 16'($urandom);
    endtask

    task automatic put(input logic [5:0] rd, input logic [5:0] rs, input logic [5:0] rt,
                       input logic [3:0] op, input logic mux, input logic [15:0] imm);
        bit done = 1'b0;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            addr_load = 1'b0;
            in_rd = rd; in_rs = rs; in_rt = rt; in_aluop = op; in_muxsel = mux; in_imm = imm;
            in_valid = 1'b1;
            done = note_accept();
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL put_timeout: in_ready stayed 0 for 50 cycles, required 1");
        end
    endtask

    task automatic put_rand();
        put(6'($urandom), 6'($urandom), 6'($urandom), 4'($urandom), 1'($urandom),
            16'($urandom_range(0, 511)));
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid  = 1'b0;
        addr_load = 1'b0;
    endtask

    // Wait for every expected word to be written, then let the write strobe drop.
    task automatic drain();
        mem_busy = 1'b0;
        for (int c = 0; c < 60 && exp_q.size() != 0; c++) @(negedge clk);
        chk("drain_words_left", exp_q.size(), 0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        addr_load = 1'b0;
        mem_busy  = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor: every write must match the next expected word
    always @(negedge clk) begin : monitor
        logic [31:0] w;
        if (rst_n && err) err_seen++;
        if (rst_n && mem_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: mem_we=1 addr=%0h data=%0h, no write expected",
                         mem_addr, mem_wdata);
            end else begin
                w = exp_q.pop_front();
                chk("wdata", mem_wdata, w);
                chk("waddr", 32'(mem_addr), 32'(model_addr));
                if (model_addr == '1) exp_wrapped = 1'b1;
                model_addr = model_addr + 1'b1;
                if (exp_wr < 65535) exp_wr++;
                chk("wr_count", 32'(wr_count), exp_wr);
                chk("wrapped", wrapped, exp_wrapped);
            end
        end
    end

    initial begin
        int n;
        int full_seen;
        int err_base;
        rst_n = 1'b0; in_valid = 1'b0; addr_load = 1'b0; addr_base = '0; mem_busy = 1'b0;
        in_rd = '0; in_rs = '0; in_rt = '0; in_aluop = '0; in_muxsel = 1'b0; in_imm = '0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_wr_count", 32'(wr_count), 0);
        chk("rst_wrapped", wrapped, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        #1 chk("ready_after_release", in_ready, 1);

        // Single tuple: latency and encoding
        put(6'd3, 6'd5, 6'd7, 4'b0010, 1'b0, 16'h001A);
        idle();
        chk("single_not_early", mem_we, 0);
        @(negedge clk);
        chk("single_we", mem_we, 1);
        chk("single_wdata", mem_wdata, 32'h0629_0E1A);
        chk("single_addr", 32'(mem_addr), 0);
        chk("single_wr_count", 32'(wr_count), 1);
        drain();

        // Burst of 6 against a stalled memory
        do_reset();
        mem_busy  = 1'b1;
        n         = 0;
        full_seen = 0;
        for (int c = 0; c < 40 && n < 6; c++) begin
            @(negedge clk);
            if (n == 4 && full_seen < 3) begin
                chk("burst_ready_low", in_ready, 0);
                chk("burst_no_write_busy", mem_we, 0);
                full_seen++;
                if (full_seen == 3) mem_busy = 1'b0;
            end
            set_rand(1'b1);
            in_valid = 1'b1;
            if (note_accept()) n++;
        end
        chk("burst_accepts", n, 6);
        idle();
        drain();

        // Base load with a coincident accept, then wrap through FF -> 00
        @(negedge clk);
        addr_load = 1'b1;
        addr_base = 8'hFE;
        set_rand(1'b1);
        in_valid = 1'b1;
        model_addr  = 8'hFE;
        exp_wrapped = 1'b0;
        void'(note_accept());
        @(negedge clk);
        addr_load = 1'b0;
        in_valid  = 1'b0;
        chk("legal_load_no_err", err, 0);
        put_rand();
        put_rand();
        idle();
        drain();
        chk("wrapped_after_wrap", wrapped, 1);

        // Load while words are queued: rejected, addresses carry on
        mem_busy = 1'b1;
        put_rand();
        put_rand();
        idle();
        addr_load = 1'b1;
        addr_base = 8'h40;
        @(negedge clk);
        addr_load = 1'b0;
        chk("bad_load_err", err, 1);
        @(negedge clk);
        chk("bad_load_err_one_cycle", err, 0);
        drain();
        chk("wrapped_kept_after_bad_load", wrapped, 1);

        // Immediate out of 9-bit range
        do_reset();
        put(6'd1, 6'd2, 6'd3, 4'd4, 1'b1, 16'h0200);
        idle();
`ifdef INST_ENC_IMM_CHECK_EN
        chk("imm_range_err", err, 1);
        drain();
        chk("imm_dropped_count", 32'(wr_count), 0);
`else
        chk("imm_range_no_err", err, 0);
        drain();
        chk("imm_truncated_count", 32'(wr_count), 1);
`endif

        // Reset while three words are queued
        mem_busy = 1'b1;
        put_rand();
        put_rand();
        put_rand();
        idle();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_mem_we", mem_we, 0);
        chk("midrst_mem_addr", 32'(mem_addr), 0);
        chk("midrst_mem_wdata", mem_wdata, 0);
        chk("midrst_wr_count", 32'(wr_count), 0);
        chk("midrst_wrapped", wrapped, 0);
        chk("midrst_err", err, 0);
        clear_model();
        mem_busy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("midrst_no_writes", 32'(wr_count), 0);

        // Random traffic with random stalls
        exp_err  = 0;
        err_base = err_seen;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            set_rand($urandom_range(0, 3) != 0);
            in_valid = 1'($urandom);
            mem_busy = ($urandom_range(0, 3) == 0);
            void'(note_accept());
        end
        idle();
        drain();
        chk("random_err_pulses", err_seen - err_base, exp_err);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
